// File: rtl/sad_candidate_tracker_if.sv
// Pixel-pair stream and result bus between a search driver and the SAD engine.
//   master: drives start, pix_valid, pix_a/pix_b, cand_v1/cand_v0/cand_last;
//           observes pix_ready, busy, done, v1/v0/MIN.
//   slave : the SAD engine (sad_candidate_tracker).
interface sad_candidate_tracker_if #(
  parameter int unsigned PIX_W = 8
);
  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_a;
  logic [PIX_W-1:0] pix_b;
  logic [31:0]      cand_v1;
  logic [31:0]      cand_v0;
  logic             cand_last;
  logic             busy;
  logic             done;
  logic [31:0]      v1;
  logic [31:0]      v0;
  logic [31:0]      MIN;

  modport master (
    output start, pix_valid, pix_a, pix_b, cand_v1, cand_v0, cand_last,
    input  pix_ready, busy, done, v1, v0, MIN
  );

  modport slave (
    input  start, pix_valid, pix_a, pix_b, cand_v1, cand_v0, cand_last,
    output pix_ready, busy, done, v1, v0, MIN
  );
endinterface

// File: rtl/sad_candidate_tracker.sv
// Per-core SAD engine feeding the minimum-SAD reducer.
// Accumulates |a-b| over BLK_PIXELS pixel pairs per candidate, keeps the
// running minimum SAD and its motion vector for one search, and presents
// v1/v0/MIN with a one-cycle done pulse when the last candidate is compared.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-high reset
//   bus  - sad_candidate_tracker_if.slave (pixel stream in, result out)
// Configuration macro:
//   SAD_TIE_LATEST_EN - when defined, an equal SAD replaces the running
//                       minimum (latest candidate wins); otherwise earliest wins.
module sad_candidate_tracker #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BLK_PIXELS = 16,
  parameter int unsigned MIN_INIT   = 10000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  sad_candidate_tracker_if.slave  bus
);

  localparam int unsigned CNT_W = (BLK_PIXELS > 2) ? $clog2(BLK_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_PIXELS - 1);
  localparam logic [31:0]      MIN_SEED = 32'(MIN_INIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      min_run_q, min_run_d;
  logic [31:0]      best_v1_q, best_v1_d;
  logic [31:0]      best_v0_q, best_v0_d;
  logic [31:0]      cand_v1_q, cand_v1_d;
  logic [31:0]      cand_v0_q, cand_v0_d;
  logic             cand_last_q, cand_last_d;
  logic [31:0]      v1_q, v1_d;
  logic [31:0]      v0_q, v0_d;
  logic [31:0]      min_q, min_d;
  logic             pix_ready_q, pix_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PIX_W-1:0] diff_c;
  logic             upd_c;

  // Absolute difference of the presented pixel pair.
  assign diff_c = (bus.pix_a >= bus.pix_b) ? (bus.pix_a - bus.pix_b)
                                           : (bus.pix_b - bus.pix_a);

  // Replace-the-minimum rule; the tie policy must match the reducer.
`ifdef SAD_TIE_LATEST_EN
  assign upd_c = (acc_q <= min_run_q);
`else
  assign upd_c = (acc_q < min_run_q);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    min_run_d   = min_run_q;
    best_v1_d   = best_v1_q;
    best_v0_d   = best_v0_q;
    cand_v1_d   = cand_v1_q;
    cand_v0_d   = cand_v0_q;
    cand_last_d = cand_last_q;
    v1_d        = v1_q;
    v0_d        = v0_q;
    min_d       = min_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          min_run_d = MIN_SEED;
          best_v1_d = '0;
          best_v0_d = '0;
        end
      end

      S_ACCUM: begin
        if (bus.start) begin
          // Abort: the pair presented this cycle is dropped.
          acc_d     = '0;
          cnt_d     = '0;
          min_run_d = MIN_SEED;
          best_v1_d = '0;
          best_v0_d = '0;
        end else if (bus.pix_valid) begin
          acc_d = acc_q + 32'(diff_c);
          if (cnt_q == '0) begin
            cand_v1_d   = bus.cand_v1;
            cand_v0_d   = bus.cand_v0;
            cand_last_d = bus.cand_last;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = S_CMP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_CMP: begin
        if (bus.start) begin
          state_d   = S_ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          min_run_d = MIN_SEED;
          best_v1_d = '0;
          best_v0_d = '0;
        end else begin
          if (upd_c) begin
            min_run_d = acc_q;
            best_v1_d = cand_v1_q;
            best_v0_d = cand_v0_q;
          end
          if (cand_last_q) begin
            // Results load on entry to DONE so they are valid with done.
            state_d = S_DONE;
            v1_d    = best_v1_d;
            v0_d    = best_v0_d;
            min_d   = min_run_d;
          end else begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    pix_ready_d = (state_d == S_ACCUM);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      min_run_q   <= MIN_SEED;
      best_v1_q   <= '0;
      best_v0_q   <= '0;
      cand_v1_q   <= '0;
      cand_v0_q   <= '0;
      cand_last_q <= 1'b0;
      v1_q        <= '0;
      v0_q        <= '0;
      min_q       <= MIN_SEED;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      min_run_q   <= min_run_d;
      best_v1_q   <= best_v1_d;
      best_v0_q   <= best_v0_d;
      cand_v1_q   <= cand_v1_d;
      cand_v0_q   <= cand_v0_d;
      cand_last_q <= cand_last_d;
      v1_q        <= v1_d;
      v0_q        <= v0_d;
      min_q       <= min_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.v1        = v1_q;
  assign bus.v0        = v0_q;
  assign bus.MIN       = min_q;

endmodule

// File: tb/tb_sad_candidate_tracker.sv
// Bench for sad_candidate_tracker: a 16-pixel and a 64-pixel instance share
// one stimulus driver (steered by sel); per-instance monitors pop expected
// results from scoreboard queues whenever done pulses.
module tb_sad_candidate_tracker;

  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v0;
    logic [31:0] mn;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        sel = 1'b0;
  logic        st  = 1'b0;
  logic        pv  = 1'b0;
  logic [7:0]  pa  = '0;
  logic [7:0]  pb  = '0;
  logic [31:0] cv1 = '0;
  logic [31:0] cv0 = '0;
  logic        cl  = 1'b0;
  logic        rdy;
  logic        bsy;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q16[$];
  exp_t q64[$];

  sad_candidate_tracker_if #(.PIX_W(8)) ifc16 ();
  sad_candidate_tracker_if #(.PIX_W(8)) ifc64 ();

  assign ifc16.start     = st & ~sel;
  assign ifc16.pix_valid = pv & ~sel;
  assign ifc16.pix_a     = pa;
  assign ifc16.pix_b     = pb;
  assign ifc16.cand_v1   = cv1;
  assign ifc16.cand_v0   = cv0;
  assign ifc16.cand_last = cl;
  assign ifc64.start     = st & sel;
  assign ifc64.pix_valid = pv & sel;
  assign ifc64.pix_a     = pa;
  assign ifc64.pix_b     = pb;
  assign ifc64.cand_v1   = cv1;
  assign ifc64.cand_v0   = cv0;
  assign ifc64.cand_last = cl;
  assign rdy = sel ? ifc64.pix_ready : ifc16.pix_ready;
  assign bsy = sel ? ifc64.busy      : ifc16.busy;

  sad_candidate_tracker #(.PIX_W(8), .BLK_PIXELS(16), .MIN_INIT(10000)) u_dut16 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc16.slave)
  );

  sad_candidate_tracker #(.PIX_W(8), .BLK_PIXELS(64), .MIN_INIT(10000)) u_dut64 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc64.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare on every done pulse.
  always @(negedge Clk) begin
    if (!Rst && ifc16.done) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'(ifc16.done), 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("v1_16", ifc16.v1, e.v1);
        chk("v0_16", ifc16.v0, e.v0);
        chk("min_16", ifc16.MIN, e.mn);
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst && ifc64.done) begin
      if (q64.size() == 0) begin
        chk("done64_unexpected", 32'(ifc64.done), 32'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("v1_64", ifc64.v1, e.v1);
        chk("v0_64", ifc64.v0, e.v0);
        chk("min_64", ifc64.MIN, e.mn);
      end
    end
  end

  task automatic do_start();
    st = 1'b1;
    @(negedge Clk);
    st = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!rdy && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bsy && t < 40) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 40) chk("idle_timeout", 32'(bsy), 32'd0);
  endtask

  // One candidate: all pairs (a,b) except the last (al,bl); operands swap on
  // odd pixels so both signs of a-b are exercised. Vector/last are only
  // meaningful on the first pair; later pairs carry junk.
  task automatic send_cand(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] al, input logic [7:0] bl,
                           input logic [31:0] v1, input logic [31:0] v0,
                           input logic last, input bit gap);
    int n;
    n = sel ? 64 : 16;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        pv = 1'b0;
        @(negedge Clk);
        if (i > 0) chk("ready_in_gap", 32'(rdy), 32'd1);
      end
      pa = (i == n - 1) ? al : a;
      pb = (i == n - 1) ? bl : b;
      if (i % 2 == 1) begin
        logic [7:0] tmp;
        tmp = pa;
        pa  = pb;
        pb  = tmp;
      end
      cv1 = (i == 0) ? v1 : 32'hDEAD_0000 + 32'(i);
      cv0 = (i == 0) ? v0 : 32'hBEEF_0000 + 32'(i);
      cl  = (i == 0) ? last : ~last;
      pv  = 1'b1;
      wait_ready();
      @(negedge Clk);
    end
    pv = 1'b0;
  endtask

  task automatic three_cand(input bit gap);
    do_start();
    send_cand(8'd20, 8'd8,  8'd30, 8'd10, 32'd0, 32'd0, 1'b0, gap); // 200
    send_cand(8'd50, 8'd56, 8'd50, 8'd56, 32'd1, 32'd2, 1'b0, gap); // 96
    send_cand(8'd0,  8'd10, 8'd5,  8'd5,  32'd2, 32'd1, 1'b1, gap); // 150
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(ifc16.pix_ready), 32'd0);
    chk("rst_busy", 32'(ifc16.busy), 32'd0);
    chk("rst_done", 32'(ifc16.done), 32'd0);
    chk("rst_min", ifc16.MIN, 32'd10000);
    chk("rst_v1", ifc16.v1, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    // Single candidate with latency check: SAD 16*3 = 48.
    e = '{v1: 32'd3, v0: 32'd5, mn: 32'd48};
    q16.push_back(e);
    do_start();
    chk("idle_to_accum_ready", 32'(rdy), 32'd1);
    send_cand(8'd10, 8'd7, 8'd10, 8'd7, 32'd3, 32'd5, 1'b1, 1'b0);
    chk("cmp_ready", 32'(rdy), 32'd0);
    chk("cmp_done", 32'(ifc16.done), 32'd0);
    @(negedge Clk);
    chk("done_latency", 32'(ifc16.done), 32'd1);
    chk("done_busy", 32'(ifc16.busy), 32'd1);
    @(negedge Clk);
    chk("done_width", 32'(ifc16.done), 32'd0);
    chk("idle_busy", 32'(ifc16.busy), 32'd0);
    chk("hold_min", ifc16.MIN, 32'd48);

    // Asynchronous reset mid-ACCUM.
    do_start();
    pv = 1'b1; pa = 8'd1; pb = 8'd0;
    repeat (3) @(negedge Clk);
    pv = 1'b0;
    chk("pre_rst_busy", 32'(ifc16.busy), 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ifc16.pix_ready), 32'd0);
    chk("arst_busy", 32'(ifc16.busy), 32'd0);
    chk("arst_done", 32'(ifc16.done), 32'd0);
    chk("arst_min", ifc16.MIN, 32'd10000);
    chk("arst_v1", ifc16.v1, 32'd0);
    chk("arst_v0", ifc16.v0, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Three candidates back-to-back.
    e = '{v1: 32'd1, v0: 32'd2, mn: 32'd96};
    q16.push_back(e);
    three_cand(1'b0);

    // Equal SADs of 64.
`ifdef SAD_TIE_LATEST_EN
    e = '{v1: 32'd7, v0: 32'd7, mn: 32'd64};
`else
    e = '{v1: 32'd4, v0: 32'd4, mn: 32'd64};
`endif
    q16.push_back(e);
    do_start();
    send_cand(8'd9, 8'd5, 8'd9, 8'd5, 32'd4, 32'd4, 1'b0, 1'b0);
    send_cand(8'd1, 8'd5, 8'd1, 8'd5, 32'd7, 32'd7, 1'b1, 1'b0);
    wait_idle();

    // Abort after 5 pairs; the pair presented with start is dropped.
    do_start();
    pv = 1'b1; pa = 8'd3; pb = 8'd0; cv1 = 32'd11; cv0 = 32'd11; cl = 1'b1;
    repeat (5) @(negedge Clk);
    st = 1'b1; pa = 8'd255; pb = 8'd0;
    @(negedge Clk);
    st = 1'b0; pv = 1'b0;
    chk("abort_busy", 32'(ifc16.busy), 32'd1);
    e = '{v1: 32'd9, v0: 32'd1, mn: 32'd32};
    q16.push_back(e);
    send_cand(8'd2, 8'd0, 8'd2, 8'd0, 32'd9, 32'd1, 1'b1, 1'b0);
    wait_idle();

    // Same three candidates with pix_valid toggling.
    e = '{v1: 32'd1, v0: 32'd2, mn: 32'd96};
    q16.push_back(e);
    three_cand(1'b1);

    // 64-pixel instance: both SADs 16320 exceed the seed.
    sel = 1'b1;
    @(negedge Clk);
    e = '{v1: 32'd0, v0: 32'd0, mn: 32'd10000};
    q64.push_back(e);
    do_start();
    send_cand(8'd255, 8'd0, 8'd255, 8'd0, 32'd5, 32'd6, 1'b0, 1'b0);
    send_cand(8'd0, 8'd255, 8'd0, 8'd255, 32'd8, 32'd9, 1'b1, 1'b0);
    wait_idle();
    repeat (2) @(negedge Clk);

    chk("pending16", 32'(q16.size()), 32'd0);
    chk("pending64", 32'(q64.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
